div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Iterative restoring divider sequencer for the EX stage, backing the DIV/DIVU
//  instructions that write HI/LO. Each operation takes WIDTH+2 cycles.
//  EX starts an operation with start_i and holds the pipeline through stallreq_o.
//  The 2*WIDTH-bit result goes to the HI/LO write path: remainder in the upper half, quotient in the lower half.
//  annul_i cancels an in-flight operation (branch/exception flush).
// PARAMETERS
//  WIDTH   32   operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          reset; synchronous, active-high
//  start_i       in   1          request a divide; held high by EX until ready_o is seen
//  annul_i       in   1          cancel the current or pending divide
//  signed_div_i  in   1          1=DIV (two's complement), 0=DIVU
//  opdata1_i     in   WIDTH      dividend; sampled only on the accepting edge
//  opdata2_i     in   WIDTH      divisor; sampled only on the accepting edge
//  result_o      out  2*WIDTH    {remainder, quotient}; registered
//  ready_o       out  1          result_o valid; registered
//  stallreq_o    out  1          stall request to the pipeline controller; combinational
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, cnt=0, ready_o=0, result_o=0, working regs=0.
//    rst overrides all other inputs, including during ON or END.
//  FSM states: IDLE, DIVZERO, ON, END.
//  IDLE:
//    - start_i=1, annul_i=0, opdata2_i==0 -> DIVZERO.
//    - start_i=1, annul_i=0, opdata2_i!=0 -> ON, with cnt=0.
//      Latch |op1| and |op2| when signed_div_i=1, raw operands otherwise.
//      Latch signed_div_i, sign(op1) and sign(op2) for the final fix-up.
//    - Otherwise stay in IDLE. This includes start_i=annul_i=1.
//  DIVZERO: next edge -> END with result_o=0. No trap is raised.
//  ON, while cnt<WIDTH, each edge does one restoring step:
//    - partial remainder = {rem,next dividend bit}; subtract divisor.
//    - If there is no borrow, keep the difference and shift in quotient bit 1.
//    - Otherwise keep the partial remainder and shift in 0.
//    - cnt increments by 1.
//  ON, with cnt==WIDTH: next edge applies the sign fix-up, loads result_o, sets ready_o=1 -> END.
//    - signed: quotient negated if sign(op1)^sign(op2); remainder negated if sign(op1).
//    - All arithmetic is modulo 2^WIDTH. MIN_INT/-1 gives quotient 0x80000000, remainder 0.
//  ON or DIVZERO with annul_i=1 at an edge -> IDLE. ready_o stays 0 and result_o stays 0.
//  END:
//    - start_i=1, annul_i=0 -> hold state; result_o and ready_o are held.
//      No restart occurs; EX must drop start_i.
//    - start_i=0 or annul_i=1 -> IDLE. ready_o=0 and result_o=0 on that edge.
//  Latency: let E0 be the edge that accepts start_i.
//    - Normal divide: ready_o=1 after edge E0+WIDTH+1.
//    - Divide by zero: ready_o=1 after edge E0+1.
//  stallreq_o = start_i & ~annul_i & (state!=END). It is 0 in END so EX advances that cycle.
//  The latched operands are not affected by opdata changes after E0.
// TESTING
//  1. DIVU 100/7: start at E0 -> ready_o rises after E0+33; result_o=0x00000002_0000000E.
//     stallreq_o=1 through cycle E0+32.
//  2. DIV -7/2: result_o={0xFFFFFFFF,0xFFFFFFFD}.
//     DIV 7/-2 -> {0x00000001,0xFFFFFFFD}.
//  3. DIV 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}.
//     DIVU 0xFFFFFFFF/1 -> {0,0xFFFFFFFF}.
//  4. Divisor 0 (DIV and DIVU): ready_o=1 after E0+1, result_o=0. Then drop start_i -> IDLE next edge.
//  5. annul_i=1 at cnt=10: IDLE next edge, ready_o never rises, stallreq_o=0.
//     An immediate new DIVU 9/3 then returns {0,3}.
//  6. rst=1 mid-ON and during END: all outputs 0 next edge, state IDLE.
//     Also: start_i held high in END keeps result_o stable for 5 cycles.
//     start_i=annul_i=1 in IDLE stays idle.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for DIV/DIVU in the EX stage.
// One quotient bit is produced per cycle. A normal divide takes WIDTH+2 cycles
// from the accepting edge up to and including the cycle in which ready_o is seen.
//
// Handshake: EX raises start_i with its operands and keeps start_i high.
// The operands are sampled only on the edge that moves the FSM out of IDLE.
// stallreq_o holds the pipeline while the divide is busy.
// ready_o/result_o are registered and are valid in END.
// In END stallreq_o is 0, so EX advances and drops start_i, and the FSM then returns to IDLE.
// annul_i cancels a busy divide without producing a result.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0]   dq_q, dq_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sdiv_q, sdiv_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  // Datapath helpers
  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_dq;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic               op1_neg;
  logic               op2_neg;

  // One restoring step, the sign fix-up, and operand magnitudes for acceptance.
  always_comb begin
    partial = {rem_q, dq_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    // The partial remainder is below 2*divisor, so bit WIDTH of the difference is the borrow.
    borrow   = diff[WIDTH];
    step_rem = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    step_dq  = {dq_q[WIDTH-2:0], ~borrow};
    q_fix    = (sdiv_q && (neg1_q ^ neg2_q)) ? (~dq_q + 1'b1) : dq_q;
    r_fix    = (sdiv_q && neg1_q) ? (~rem_q + 1'b1) : rem_q;
    op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
    op1_abs  = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_abs  = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // Next-state and register-update logic of the divider FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dq_d     = dq_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    sdiv_d   = sdiv_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            dq_d    = op1_abs;
            dvs_d   = op2_abs;
            rem_d   = '0;
            sdiv_d  = signed_div_i;
            neg1_d  = op1_neg;
            neg2_d  = op2_neg;
          end
        end
      end
      S_DIVZERO: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          // Divide by zero completes quietly with a zero result.
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {r_fix, q_fix};
        end else begin
          rem_d = step_rem;
          dq_d  = step_dq;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_END: begin
        // Holding start_i here keeps the result; it never restarts a divide.
        if (!start_i || annul_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and working registers; rst clears everything synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      sdiv_q   <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      sdiv_q   <= sdiv_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~annul_i & (state_q != S_END);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized checks of div_seq against an
// arithmetic reference model (native 64-bit division).
module tb_div_seq;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;

  int n_cmp;
  int n_err;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {remainder, quotient} computed from plain arithmetic.
  function automatic logic [2*W-1:0] ref_div(input logic sd, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (b == '0) return '0;
    if (!sd) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Issue one divide, measure latency, check result, hold in END, then release.
  task automatic run_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input int hold, input string name);
    int exp_lat;
    int lat;
    exp_lat      = (b == '0) ? 1 : W + 1;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    tick();
    // Operands change after acceptance; the latched copies must be used.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      n_cmp++;
      if (stallreq_o !== 1'b1 || ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy: stallreq=%b ready=%b, required stallreq=1 ready=0 (cycle %0d)",
                 name, stallreq_o, ready_o, k);
      end
      tick();
      if (ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, required %0d (0 = timeout)", name, lat, exp_lat);
    end
    n_cmp++;
    if (result_o !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h, required %h", name, result_o, exp);
    end
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s end_stall: got %b, required 0", name, stallreq_o);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      n_cmp++;
      if (ready_o !== 1'b1 || result_o !== exp || stallreq_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold: ready=%b result=%h stall=%b, required ready=1 result=%h stall=0",
                 name, ready_o, result_o, stallreq_o, exp);
      end
    end
    start_i = 1'b0;
    tick();
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== '0) begin
      n_err++;
      $display("FAIL %s release: ready=%b result=%h, required ready=0 result=0",
               name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = 1'b1;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    repeat (3) tick();
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== '0) begin
      n_err++;
      $display("FAIL reset_out: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    n_cmp++;
    if (stallreq_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_stall: got %b, required 1 (idle with start)", stallreq_o);
    end
    start_i = 1'b0;
    rst     = 1'b0;
    tick();
    n_cmp++;
    if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: ready=%b stall=%b, required 0/0", ready_o, stallreq_o);
    end
  endtask

  task automatic test_directed();
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, "divu_100_7");
    run_div(1'b1, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0, "div_m7_2");
    run_div(1'b1, 32'd7, -32'sd2, 64'h00000001_FFFFFFFD, 0, "div_7_m2");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, "div_min_m1");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0, "divu_max_1");
  endtask

  task automatic test_divzero();
    run_div(1'b1, 32'd1234, 32'd0, 64'd0, 0, "div_by_zero");
    run_div(1'b0, 32'hDEADBEEF, 32'd0, 64'd0, 1, "divu_by_zero");
  endtask

  task automatic test_annul();
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL annul_busy: ready=%b, required 0 (cycle %0d)", ready_o, k);
      end
      tick();
    end
    annul_i = 1'b1;
    #1;
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_err++;
      $display("FAIL annul_stall: got %b, required 0", stallreq_o);
    end
    tick();
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== '0 || stallreq_o !== 1'b0) begin
      n_err++;
      $display("FAIL annul_idle: ready=%b result=%h stall=%b, required 0/0/0",
               ready_o, result_o, stallreq_o);
    end
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0, "after_annul_9_3");
  endtask

  task automatic test_start_annul_idle();
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd10;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
        n_err++;
        $display("FAIL start_annul_idle: ready=%b stall=%b, required 0/0", ready_o, stallreq_o);
      end
    end
    run_div(1'b0, 32'd77, 32'd5, 64'h00000002_0000000F, 0, "after_start_annul");
  endtask

  task automatic test_reset_mid();
    int seen;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1234;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    start_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== '0) begin
      n_err++;
      $display("FAIL reset_mid_on: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    tick();
    run_div(1'b1, -32'sd100, 32'd9, ref_div(1'b1, -32'sd100, 32'd9), 0, "after_reset_on");
    // Reset while sitting in END.
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    seen      = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (seen != 1) begin
      n_err++;
      $display("FAIL reset_end_reach: ready never rose, required within 40 cycles");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== '0 || stallreq_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_end: ready=%b result=%h stall=%b, required 0/0/1",
               ready_o, result_o, stallreq_o);
    end
    start_i = 1'b0;
    tick();
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 5, "hold_5_cycles");
  endtask

  task automatic test_random();
    logic         sd;
    logic [W-1:0] a, b;
    int           sel;
    for (int i = 0; i < 150; i++) begin
      sd  = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = '0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4:       b = 32'($urandom_range(1, 255));
        5:       b = a;
        default: b = $urandom;
      endcase
      run_div(sd, a, b, ref_div(sd, a, b), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    test_reset();
    test_directed();
    test_divzero();
    test_annul();
    test_start_annul_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
